// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - state encodings, default parameters and helpers for run_sequencer
package run_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADING = 3'd1,
        S_READY   = 3'd2,
        S_RUNNING = 3'd3,
        S_PAUSED  = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } seq_state_e;

    // Core reset / load_start sequencing that runs ahead of LOADING
    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_RST  = 2'd1,
        PH_GAP  = 2'd2
    } boot_phase_e;

    localparam int DEF_DEBOUNCE_CYCLES = 100000;
    localparam int DEF_LOAD_TIMEOUT    = 20000;
    localparam int DEF_CORE_RST_CYCLES = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// rtl/run_sequencer_if.sv - core-facing control/status bundle of run_sequencer
interface run_sequencer_if;
    logic        core_loaded;
    logic        core_halted;
    logic        core_resetn;
    logic        load_start;
    logic        core_run;
    logic        core_step;
    logic [2:0]  state_id;
    logic        load_err;
    logic [31:0] cycle_count;

    modport master (
        input  core_loaded, core_halted,
        output core_resetn, load_start, core_run, core_step, state_id, load_err, cycle_count
    );

    modport slave (
        output core_loaded, core_halted,
        input  core_resetn, load_start, core_run, core_step, state_id, load_err, cycle_count
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, stability counter and rising-edge pulse for one button
module btn_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the accepted level
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - button-driven load/run/pause/step sequencer for a soft core
// Single-step support (BTN2, core_step) is built only with SEQ_SINGLE_STEP_EN defined.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOAD_TIMEOUT    = DEF_LOAD_TIMEOUT,
    parameter int CORE_RST_CYCLES = DEF_CORE_RST_CYCLES
) (
    input  logic              CLK,
    input  logic              BTN_N,
    input  logic              BTN1,
    input  logic              BTN2,
    input  logic              BTN3,
    run_sequencer_if.master   bus
);
    localparam int TW  = $clog2(LOAD_TIMEOUT + 1);
    localparam int RCW = $clog2(CORE_RST_CYCLES + 1);

    logic start_p, step_p, load_p;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(CLK), .rst_n(BTN_N), .btn(BTN1), .pulse(start_p)
    );
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(CLK), .rst_n(BTN_N), .btn(BTN3), .pulse(load_p)
    );
`ifdef SEQ_SINGLE_STEP_EN
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(CLK), .rst_n(BTN_N), .btn(BTN2), .pulse(step_p)
    );
`else
    logic unused_btn2;
    assign unused_btn2 = BTN2;
    assign step_p      = 1'b0;
`endif

    seq_state_e     state_q, state_d;
    boot_phase_e    phase_q, phase_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           core_resetn_q, core_resetn_d;
    logic           load_start_q, load_start_d;
    logic           core_run_q, core_run_d;
    logic           core_step_q, core_step_d;
    logic           load_err_q, load_err_d;
    logic [31:0]    cycle_count_q, cycle_count_d;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        rst_cnt_d     = rst_cnt_q;
        tmr_d         = tmr_q;
        core_resetn_d = 1'b1;
        load_start_d  = 1'b0;
        core_run_d    = core_run_q;
        core_step_d   = 1'b0;
        load_err_d    = load_err_q;
        cycle_count_d = cycle_count_q;

        // Load wins over everything and restarts the boot sequence from scratch
        if (load_p) begin
            state_d       = S_IDLE;
            phase_d       = PH_RST;
            rst_cnt_d     = RCW'(CORE_RST_CYCLES - 1);
            core_resetn_d = 1'b0;
            core_run_d    = 1'b0;
        end else if (phase_q == PH_RST) begin
            if (rst_cnt_q == '0) begin
                phase_d = PH_GAP;
            end else begin
                rst_cnt_d     = rst_cnt_q - 1'b1;
                core_resetn_d = 1'b0;
            end
        end else if (phase_q == PH_GAP) begin
            phase_d      = PH_NONE;
            load_start_d = 1'b1;
            state_d      = S_LOADING;
            load_err_d   = 1'b0;
            tmr_d        = '0;
        end else begin
            unique case (state_q)
                S_LOADING: begin
                    if (bus.core_loaded) begin
                        state_d = S_READY;
                    end else if (tmr_q == TW'(LOAD_TIMEOUT - 1)) begin
                        state_d    = S_ERROR;
                        load_err_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_READY: begin
                    if (start_p) begin
                        cycle_count_d = '0;
                        state_d       = S_RUNNING;
                        core_run_d    = 1'b1;
                    end else if (step_p) begin
                        core_step_d = 1'b1;
                        state_d     = S_PAUSED;
                    end
                end
                S_RUNNING: begin
                    cycle_count_d = sat_inc(cycle_count_q);
                    if (bus.core_halted) begin
                        state_d    = S_DONE;
                        core_run_d = 1'b0;
                    end else if (start_p) begin
                        state_d    = S_PAUSED;
                        core_run_d = 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (bus.core_halted) begin
                        state_d = S_DONE;
                    end else if (start_p) begin
                        state_d    = S_RUNNING;
                        core_run_d = 1'b1;
                    end else if (step_p) begin
                        core_step_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            state_q       <= S_IDLE;
            phase_q       <= PH_NONE;
            rst_cnt_q     <= '0;
            tmr_q         <= '0;
            core_resetn_q <= 1'b0;
            load_start_q  <= 1'b0;
            core_run_q    <= 1'b0;
            core_step_q   <= 1'b0;
            load_err_q    <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            rst_cnt_q     <= rst_cnt_d;
            tmr_q         <= tmr_d;
            core_resetn_q <= core_resetn_d;
            load_start_q  <= load_start_d;
            core_run_q    <= core_run_d;
            core_step_q   <= core_step_d;
            load_err_q    <= load_err_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.state_id    = state_q;
    assign bus.core_resetn = core_resetn_q;
    assign bus.load_start  = load_start_q;
    assign bus.core_run    = core_run_q;
    assign bus.core_step   = core_step_q;
    assign bus.load_err    = load_err_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning the number of cycles a synchronised button level must stay stable before it is accepted.
REQ-002 The block SHALL have parameter LOAD_TIMEOUT, default 20000, meaning the maximum cycles spent in LOADING before an error is flagged.
REQ-003 The block SHALL have parameter CORE_RST_CYCLES, default 4, meaning the width in cycles of the core reset pulse.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port BTN_N, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port BTN1, input, 1 bit: raw start/pause button, active-high.
REQ-007 The block SHALL have port BTN2, input, 1 bit: raw single-step button, active-high.
REQ-008 The block SHALL have port BTN3, input, 1 bit: raw load button, active-high.
REQ-009 The block SHALL have port core_loaded, input, 1 bit: the core has finished program load.
REQ-010 The block SHALL have port core_halted, input, 1 bit: the core has reached the end of the program.
REQ-011 The block SHALL have port core_resetn, output, 1 bit: active-low reset to the core.
REQ-012 The block SHALL have port load_start, output, 1 bit: one-cycle pulse that starts program load.
REQ-013 The block SHALL have port core_run, output, 1 bit: level that enables free-running execution.
REQ-014 The block SHALL have port core_step, output, 1 bit: one-cycle pulse that executes one instruction.
REQ-015 The block SHALL have port state_id, output, 3 bits: encoded current state.
REQ-016 The block SHALL have port load_err, output, 1 bit: sticky flag for a load timeout.
REQ-017 The block SHALL have port cycle_count, output, 32 bits: the number of cycles spent in RUNNING.

Function
REQ-018 Each button SHALL pass through a 2-flop synchroniser and then a stability counter, and SHALL produce exactly one 1-cycle pulse per accepted rising level, no later than DEBOUNCE_CYCLES+3 cycles after the input rises; glitches shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-019 The state machine SHALL have the states IDLE=0, LOADING=1, READY=2, RUNNING=3, PAUSED=4, DONE=5, ERROR=6; all outputs SHALL be registered.
REQ-020 An accepted load pulse in any state SHALL drive core_resetn low for exactly CORE_RST_CYCLES cycles, then pulse load_start for 1 cycle on the cycle after core_resetn rises, then enter LOADING, clear load_err, and drop core_run immediately.
REQ-021 In LOADING, core_loaded=1 SHALL move the block to READY on the next cycle; if LOADING_TIMEOUT cycles elapse without core_loaded, the block SHALL enter ERROR and set load_err=1.
REQ-022 In READY, a start pulse SHALL clear cycle_count, enter RUNNING and assert core_run on the following cycle.
REQ-023 In RUNNING, cycle_count SHALL increment every cycle and saturate at 0xFFFFFFFF; a start pulse SHALL move the block to PAUSED; core_halted SHALL move it to DONE; core_run SHALL fall on the cycle the state leaves RUNNING.
REQ-024 In PAUSED, a start pulse SHALL move the block to RUNNING without clearing cycle_count, a step pulse SHALL issue core_step, and core_halted SHALL move it to DONE.
REQ-025 In READY, a step pulse SHALL issue core_step and move the block to PAUSED.
REQ-026 In DONE and ERROR, only a load pulse SHALL be acted on; start and step pulses SHALL be discarded; cycle_count SHALL hold its value.
REQ-027 When events coincide in the same cycle, the priority SHALL be load > core_halted > start > step; a lower-priority pulse SHALL be dropped, not queued.
REQ-028 Button pulses that arrive during the core reset pulse or load_start sequence, other than load, SHALL be dropped; a new load pulse SHALL restart the reset pulse.

Reset
REQ-029 While BTN_N=0, the block SHALL hold state IDLE, core_resetn=0, load_start=0, core_run=0, core_step=0, load_err=0 and cycle_count=0, and SHALL clear all debounce counters and synchroniser flops to 0.
REQ-030 After BTN_N rises, core_resetn SHALL go to 1 on the first clock edge.

Configuration
REQ-031 With SEQ_SINGLE_STEP_EN defined, BTN2 SHALL be debounced and the step behaviour SHALL be implemented.
REQ-032 Without SEQ_SINGLE_STEP_EN, BTN2 SHALL be ignored, no BTN2 debouncer SHALL be instantiated, core_step SHALL be constant 0, and READY SHALL leave only on start or load.

Structure
REQ-033 Package run_seq_pkg SHALL hold the state enum (3-bit) and the default parameter constants.
REQ-034 Sub-module btn_debounce (synchroniser, stability counter and rising-edge pulse) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, LOAD_TIMEOUT=100, CORE_RST_CYCLES=4)
REQ-035 Hold BTN3 for 20 cycles and assert core_loaded 30 cycles later -> core_resetn low for exactly 4 cycles, one load_start pulse, state_id=1 then 2.
REQ-036 Load, hold BTN1 for 20 cycles, wait 500 cycles, raise core_halted -> core_run=1 throughout RUNNING, state_id=5, cycle_count approx 500 and then frozen.
REQ-037 Load with core_loaded never asserted -> state_id=6 and load_err=1 exactly 100 cycles after entering LOADING; a BTN3 press clears load_err.
REQ-038 In RUNNING, press BTN1, then BTN2 three times, then BTN1 (SEQ_SINGLE_STEP_EN defined) -> PAUSED, exactly 3 core_step pulses, return to RUNNING, cycle_count not reset.
REQ-039 BTN1 glitch of 2 cycles -> no state change; BTN_N pulled low in RUNNING -> all outputs return to their reset values at once.
